dmem_arbiter: RTL and testbench

- Shares the single-port synchronous data memory between the four-stage processor's load/store port (CPU) and the NoC network interface (NIC).
- Arbitrates one access per cycle and steers address, write data and enables to the memory.
- Returns read data one cycle later to the port that issued the read.
- Gives the CPU priority, with two exceptions: an aging counter forces a starved NIC through, and a bounded NIC lock mode supports packet bursts.

---
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory arbiter between CPU load/store port and NoC NIC
// CPU-priority arbitration with NIC aging, bounded NIC burst lock and one-cycle read return steering.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 4,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req_i,
    input  logic              cpu_wr_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              nic_req_i,
    input  logic              nic_wr_i,
    input  logic              nic_lock_i,
    input  logic [ADDR_W-1:0] nic_addr_i,
    input  logic [DATA_W-1:0] nic_wdata_i,
    output logic              nic_gnt_o,
    output logic              nic_rvalid_o,
    output logic [DATA_W-1:0] nic_rdata_o,
    output logic              mem_en_o,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              lock_active_o
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int LOCK_W = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        NIC_LOCK  = 2'd1,
        CPU_FIRST = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   nic_wait_q, nic_wait_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [LOCK_W-1:0]   lock_cnt_inc;
    logic                cpu_rvalid_q, nic_rvalid_q;
    logic                cpu_gnt, nic_gnt;

    always_comb begin
        cpu_gnt = 1'b0;
        nic_gnt = 1'b0;
        case (state_q)
            ARB: begin
                if (nic_req_i && nic_wait_q == WAIT_W'(MAX_WAIT)) begin
                    nic_gnt = 1'b1;
                end else if (cpu_req_i) begin
                    cpu_gnt = 1'b1;
                end else begin
                    nic_gnt = nic_req_i;
                end
            end
            NIC_LOCK: nic_gnt = nic_req_i;
            CPU_FIRST: begin
                if (cpu_req_i) begin
                    cpu_gnt = 1'b1;
                end else begin
                    nic_gnt = nic_req_i;
                end
            end
            default: ;
        endcase
        if (!reset) begin
            cpu_gnt = 1'b0;
            nic_gnt = 1'b0;
        end
    end

    // The ARB grant that opens a burst already counts as the first of LOCK_MAX.
    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        lock_cnt_inc = lock_cnt_q + LOCK_W'(nic_gnt);
        case (state_q)
            ARB: begin
                lock_cnt_d = '0;
                if (nic_gnt && nic_lock_i) begin
                    if (LOCK_MAX == 1) begin
                        state_d = CPU_FIRST;
                    end else begin
                        state_d    = NIC_LOCK;
                        lock_cnt_d = LOCK_W'(1);
                    end
                end
            end
            NIC_LOCK: begin
                if (!nic_lock_i) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                end else if (lock_cnt_inc == LOCK_W'(LOCK_MAX)) begin
                    state_d    = CPU_FIRST;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_inc;
                end
            end
            default: begin
                state_d    = ARB;
                lock_cnt_d = '0;
            end
        endcase

        if (nic_req_i && !nic_gnt) begin
            nic_wait_d = (nic_wait_q == WAIT_W'(MAX_WAIT)) ? nic_wait_q : nic_wait_q + WAIT_W'(1);
        end else begin
            nic_wait_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ARB;
            nic_wait_q   <= '0;
            lock_cnt_q   <= '0;
            cpu_rvalid_q <= 1'b0;
            nic_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            nic_wait_q   <= nic_wait_d;
            lock_cnt_q   <= lock_cnt_d;
            cpu_rvalid_q <= cpu_gnt && !cpu_wr_i;
            nic_rvalid_q <= nic_gnt && !nic_wr_i;
        end
    end

    always_comb begin
        mem_wr_en_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (cpu_gnt) begin
            mem_wr_en_o = cpu_wr_i;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
        end else if (nic_gnt) begin
            mem_wr_en_o = nic_wr_i;
            mem_addr_o  = nic_addr_i;
            mem_wdata_o = nic_wdata_i;
        end
    end

    assign mem_en_o      = cpu_gnt | nic_gnt;
    assign cpu_gnt_o     = cpu_gnt;
    assign nic_gnt_o     = nic_gnt;
    assign cpu_rvalid_o  = cpu_rvalid_q;
    assign nic_rvalid_o  = nic_rvalid_q;
    assign cpu_rdata_o   = cpu_rvalid_q ? mem_rdata_i : '0;
    assign nic_rdata_o   = nic_rvalid_q ? mem_rdata_i : '0;
    assign lock_active_o = (state_q == NIC_LOCK);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized bench for dmem_arbiter against a cycle-level reference model
// Requesters obey the hold-until-grant rule; a small RAM sits behind the memory port.
module tb_dmem_arbiter;
    localparam int AW       = 32;
    localparam int DW       = 64;
    localparam int MAX_WAIT = 4;
    localparam int LOCK_MAX = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_wr, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          nic_req, nic_wr, nic_lock, nic_gnt, nic_rvalid;
    logic [AW-1:0] nic_addr;
    logic [DW-1:0] nic_wdata, nic_rdata;
    logic          mem_en, mem_wr_en, lock_active;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req_i(cpu_req), .cpu_wr_i(cpu_wr), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
        .nic_req_i(nic_req), .nic_wr_i(nic_wr), .nic_lock_i(nic_lock), .nic_addr_i(nic_addr),
        .nic_wdata_i(nic_wdata), .nic_gnt_o(nic_gnt), .nic_rvalid_o(nic_rvalid), .nic_rdata_o(nic_rdata),
        .mem_en_o(mem_en), .mem_wr_en_o(mem_wr_en), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .lock_active_o(lock_active)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int i);
        return {32'hC0DE_0000 + 32'(i), 32'(i) * 32'h0101_0101};
    endfunction

    logic [DW-1:0] ram [16];
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
        end else if (mem_en) begin
            if (mem_wr_en) ram[mem_addr[3:0]] <= mem_wdata;
            else           mem_rdata <= ram[mem_addr[3:0]];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: burst bookkeeping, starvation age, memory image and pending read returns.
    bit            in_burst, cpu_turn, last_cg, last_ng;
    int            starve, burst_grants;
    logic [DW-1:0] mmem [16];
    bit            exp_crv, exp_nrv;
    logic [DW-1:0] exp_crd, exp_nrd;

    task automatic model_reset();
        in_burst = 0; cpu_turn = 0; starve = 0; burst_grants = 0;
        exp_crv = 0; exp_nrv = 0; last_cg = 0; last_ng = 0;
        for (int i = 0; i < 16; i++) mmem[i] = init_word(i);
    endtask

    // Stimulus state
    int p_c, p_n, lock_mode, rst_cycles;
    bit n_rd_only;

    task automatic drive();
        if (last_cg) cpu_req = 0;
        if (last_ng) nic_req = 0;
        if (cpu_req && p_c < 100 && $urandom_range(0, 15) == 0) cpu_req = 0;
        if (nic_req && p_n < 100 && $urandom_range(0, 15) == 0) nic_req = 0;
        if (!cpu_req && $urandom_range(1, 100) <= p_c) begin
            cpu_req = 1; cpu_wr = 1'($urandom_range(0, 1));
            cpu_addr = $urandom(); cpu_wdata = {$urandom(), $urandom()};
        end
        if (!nic_req && $urandom_range(1, 100) <= p_n) begin
            nic_req = 1; nic_wr = n_rd_only ? 1'b0 : 1'($urandom_range(0, 1));
            nic_addr = $urandom(); nic_wdata = {$urandom(), $urandom()};
        end
        if (lock_mode == 1)      nic_lock = 1;
        else if (lock_mode == 2) nic_lock = 0;
        else if ($urandom_range(0, 3) == 0) nic_lock = ~nic_lock;
        reset = (rst_cycles > 0) ? 1'b0 : 1'b1;
        if (rst_cycles > 0) rst_cycles--;
    endtask

    task automatic step();
        bit            cg, ng, e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        cg = 0; ng = 0;
        if (reset) begin
            if (in_burst) ng = nic_req;
            else if (cpu_turn) begin
                cg = cpu_req; ng = !cpu_req && nic_req;
            end else if (nic_req && starve == MAX_WAIT) ng = 1;
            else if (cpu_req) cg = 1;
            else ng = nic_req;
        end
        e_wr = 0; e_addr = '0; e_wd = '0;
        if (cg) begin e_wr = cpu_wr; e_addr = cpu_addr; e_wd = cpu_wdata; end
        if (ng) begin e_wr = nic_wr; e_addr = nic_addr; e_wd = nic_wdata; end

        check("cpu_gnt", cpu_gnt, cg);
        check("nic_gnt", nic_gnt, ng);
        check("mem_en", mem_en, cg | ng);
        check("mem_wr_en", mem_wr_en, e_wr);
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wd);
        check("lock_active", lock_active, in_burst);
        check("cpu_rvalid", cpu_rvalid, exp_crv);
        check("cpu_rdata", cpu_rdata, exp_crv ? exp_crd : '0);
        check("nic_rvalid", nic_rvalid, exp_nrv);
        check("nic_rdata", nic_rdata, exp_nrv ? exp_nrd : '0);

        if (!reset) begin
            model_reset();
            return;
        end
        exp_crv = cg && !cpu_wr; exp_crd = mmem[cpu_addr[3:0]];
        exp_nrv = ng && !nic_wr; exp_nrd = mmem[nic_addr[3:0]];
        if (cg && cpu_wr) mmem[cpu_addr[3:0]] = cpu_wdata;
        if (ng && nic_wr) mmem[nic_addr[3:0]] = nic_wdata;

        starve = (nic_req && !ng) ? ((starve < MAX_WAIT) ? starve + 1 : MAX_WAIT) : 0;

        if (in_burst) begin
            if (ng) burst_grants++;
            if (!nic_lock) begin
                in_burst = 0; burst_grants = 0;
            end else if (burst_grants == LOCK_MAX) begin
                in_burst = 0; burst_grants = 0; cpu_turn = 1;
            end
        end else if (cpu_turn) begin
            cpu_turn = 0;
        end else if (ng && nic_lock) begin
            in_burst = 1; burst_grants = 1;
        end
        last_cg = cg; last_ng = ng;
    endtask

    task automatic cycle();
        @(negedge clk);
        drive();
        #1;
        step();
    endtask

    initial begin
        bit hit;
        cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        nic_req = 0; nic_wr = 0; nic_lock = 0; nic_addr = '0; nic_wdata = '0;
        reset = 0; rst_cycles = 2; n_rd_only = 0;
        model_reset();

        p_c = 50; p_n = 50; lock_mode = 0;
        repeat (400) cycle();
        // Continuous contention without lock: aging must force the NIC through
        p_c = 100; p_n = 100; lock_mode = 2;
        repeat (200) cycle();
        // Lock held under contention: bounded bursts, then a guaranteed CPU slot
        lock_mode = 1;
        repeat (200) cycle();
        p_c = 40; p_n = 70; lock_mode = 0;
        repeat (400) cycle();

        // Reset while locked with a NIC read in flight
        p_c = 100; p_n = 100; lock_mode = 1; n_rd_only = 1; hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            cycle();
            if (in_burst && last_ng && !nic_wr) hit = 1;
        end
        check("reset_setup_reached", hit, 1);
        rst_cycles = 1;
        repeat (3) cycle();
        n_rd_only = 0; lock_mode = 0; p_c = 60; p_n = 60;
        repeat (300) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
